// File: rtl/pkg_opengpu.sv
// Shared GPU definitions: warp geometry and the vote operation encoding.
package pkg_opengpu;

  localparam int WARP_SIZE  = 32;
  localparam int DATA_WIDTH = 32;

  // 3-bit encoding so that unsupported opcodes can exist and be flagged as illegal.
  typedef enum logic [2:0] {
    VOTE_ALL  = 3'd0,
    VOTE_ANY  = 3'd1,
    VOTE_BAL  = 3'd2,
    VOTE_POPC = 3'd3
  } vote_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } vote_state_t;

endpackage

// File: rtl/vote_chunk_reduce.sv
// Combinational any/all/active (and, with VOTE_POPC_EN, popcount) reduction of one lane chunk.
module vote_chunk_reduce #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0]        pred,
  input  logic [CHUNK_W-1:0]        mask,
  output logic                      any_hit,
  output logic                      all_hit,
`ifdef VOTE_POPC_EN
  output logic [$clog2(CHUNK_W):0]  popc,
`endif
  output logic                      act_hit
);

  assign any_hit = |(pred & mask);
  assign all_hit = &(pred | ~mask);  // inactive lanes never veto ALL
  assign act_hit = |mask;

`ifdef VOTE_POPC_EN
  localparam int CPW = $clog2(CHUNK_W) + 1;

  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns a default first, so no latch is inferred.
    popc = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      popc = popc + CPW'(pred[i] & mask[i]);
    end
  end
`endif

endmodule

// File: rtl/vote_reduce_unit.sv
// Warp vote unit: reduces a registered predicate/mask one chunk per cycle, then holds the result.
// Optional popcount support is enabled by defining VOTE_POPC_EN.
module vote_reduce_unit
  import pkg_opengpu::*;
#(
  parameter int WARP_W  = WARP_SIZE,
  parameter int CHUNK_W = 8,
  parameter int WID_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WARP_W-1:0]     in_pred,
  input  logic [WARP_W-1:0]     in_mask,
  input  vote_op_t              in_op,
  input  logic [WID_W-1:0]      in_wid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [WID_W-1:0]      out_wid,
  output logic                  out_illegal
);

  localparam int N     = WARP_W / CHUNK_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  vote_state_t      state;
  logic [WARP_W-1:0] pred_r;
  logic [WARP_W-1:0] mask_r;
  vote_op_t          op_r;
  logic [WID_W-1:0]  wid_r;
  logic [CNT_W-1:0]  cnt;
  logic              any_acc, all_acc, act_acc;
  logic              c_any, c_all, c_act;

`ifdef VOTE_POPC_EN
  localparam int PW = $clog2(WARP_W) + 1;
  logic [PW-1:0]             popc_acc;
  logic [$clog2(CHUNK_W):0]  c_popc;
`endif

  // The active chunk is always the low slice; pred_r/mask_r rotate back to their original value after N steps.
  vote_chunk_reduce #(.CHUNK_W(CHUNK_W)) u_chunk (
    .pred    (pred_r[CHUNK_W-1:0]),
    .mask    (mask_r[CHUNK_W-1:0]),
    .any_hit (c_any),
    .all_hit (c_all),
`ifdef VOTE_POPC_EN
    .popc    (c_popc),
`endif
    .act_hit (c_act)
  );

  assign in_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pred_r      <= '0;
      mask_r      <= '0;
      op_r        <= VOTE_ALL;
      wid_r       <= '0;
      cnt         <= '0;
      any_acc     <= 1'b0;
      all_acc     <= 1'b0;
      act_acc     <= 1'b0;
`ifdef VOTE_POPC_EN
      popc_acc    <= '0;
`endif
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_wid     <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pred_r  <= in_pred & in_mask;
            mask_r  <= in_mask;
            op_r    <= in_op;
            wid_r   <= in_wid;
            cnt     <= '0;
            any_acc <= 1'b0;
            all_acc <= 1'b1;  // AND identity; an empty mask is caught by act_acc
            act_acc <= 1'b0;
`ifdef VOTE_POPC_EN
            popc_acc <= '0;
`endif
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          any_acc <= any_acc | c_any;
          all_acc <= all_acc & c_all;
          act_acc <= act_acc | c_act;
`ifdef VOTE_POPC_EN
          popc_acc <= popc_acc + PW'(c_popc);
`endif
          pred_r  <= (pred_r >> CHUNK_W) | (pred_r << (WARP_W - CHUNK_W));
          mask_r  <= (mask_r >> CHUNK_W) | (mask_r << (WARP_W - CHUNK_W));
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle formats the result; afterwards it is held until the consumer takes it.
          if (!out_valid) begin
            out_valid   <= 1'b1;
            out_wid     <= wid_r;
            out_illegal <= 1'b0;
            case (op_r)
              VOTE_ALL: out_result <= DATA_WIDTH'(all_acc & act_acc);
              VOTE_ANY: out_result <= DATA_WIDTH'(any_acc);
              VOTE_BAL: out_result <= DATA_WIDTH'(pred_r);
`ifdef VOTE_POPC_EN
              VOTE_POPC: out_result <= DATA_WIDTH'(popc_acc);
`endif
              default: begin
                out_result  <= '0;
                out_illegal <= 1'b1;
              end
            endcase
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_reduce_unit.sv
// Self-checking bench for vote_reduce_unit: vector table + scoreboard queue + corner-case sequences.
module tb_vote_reduce_unit;
  import pkg_opengpu::*;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_pred;
  logic [31:0]           in_mask;
  vote_op_t              in_op;
  logic [3:0]            in_wid;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [3:0]            out_wid;
  logic                  out_illegal;

  vote_reduce_unit #(.WARP_W(32), .CHUNK_W(8), .WID_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pred     (in_pred),
    .in_mask     (in_mask),
    .in_op       (in_op),
    .in_wid      (in_wid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_wid     (out_wid),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pred;
    logic [31:0] mask;
    vote_op_t    op;
    logic [3:0]  wid;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  wid;
    logic        ill;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model(input logic [31:0] p, input logic [31:0] m, input vote_op_t op,
                                output logic [31:0] r, output logic il);
    logic [31:0] pm;
    pm = p & m;
    il = 1'b0;
    case (op)
      VOTE_ALL: r = {31'd0, (m != 32'd0) && (pm == m)};
      VOTE_ANY: r = {31'd0, pm != 32'd0};
      VOTE_BAL: r = pm;
`ifdef VOTE_POPC_EN
      VOTE_POPC: r = $countones(pm);
`endif
      default: begin
        r  = 32'd0;
        il = 1'b1;
      end
    endcase
  endfunction

  // Drive one request; the expected result enters the scoreboard at the accept edge.
  task automatic send(input logic [31:0] p, input logic [31:0] m, input vote_op_t op,
                      input logic [3:0] w, input logic [31:0] r, input logic il);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_pred  = p;
    in_mask  = m;
    in_op    = op;
    in_wid   = w;
    @(posedge clk);
    #1;
    e.res = r;
    e.wid = w;
    e.ill = il;
    e.acc_cyc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    in_pred  = $urandom;
    in_mask  = $urandom;
    in_op    = vote_op_t'($urandom_range(0, 7));
    in_wid   = 4'($urandom);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  // Monitor: latency on the rising edge of out_valid, payload on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (sb.size() == 0) check("spurious_valid", sb.size(), 1);
        else check("latency", cyc - sb[0].acc_cyc, 5);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        check("result", out_result, e.res);
        check("wid", {28'd0, out_wid}, {28'd0, e.wid});
        check("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, p, m;
    logic        il;
    vote_op_t    op;
    int          n, rises;

    vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, VOTE_ALL, 4'd3, 32'd1, 1'b0};
    vecs[1]  = '{32'h0001_8001, 32'h0000_FFFF, VOTE_BAL, 4'd1, 32'h0000_8001, 1'b0};
    vecs[2]  = '{32'h0001_8001, 32'h0000_FFFF, VOTE_ANY, 4'd2, 32'd1, 1'b0};
    vecs[3]  = '{32'h0001_8001, 32'h0000_FFFF, VOTE_ALL, 4'd4, 32'd0, 1'b0};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0000, VOTE_ALL, 4'd5, 32'd0, 1'b0};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0000, VOTE_ANY, 4'd6, 32'd0, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0000, VOTE_BAL, 4'd7, 32'd0, 1'b0};
`ifdef VOTE_POPC_EN
    vecs[7]  = '{32'hFFFF_0000, 32'hF0F0_F0F0, VOTE_POPC, 4'd8, 32'd8, 1'b0};
    vecs[13] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, VOTE_POPC, 4'd14, 32'd32, 1'b0};
`else
    vecs[7]  = '{32'hFFFF_0000, 32'hF0F0_F0F0, VOTE_POPC, 4'd8, 32'd0, 1'b1};
    vecs[13] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, VOTE_POPC, 4'd14, 32'd0, 1'b1};
`endif
    vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, vote_op_t'(3'd6), 4'd9, 32'd0, 1'b1};
    vecs[9]  = '{32'hFFFF_00FF, 32'h00FF_00FF, VOTE_ALL, 4'd10, 32'd1, 1'b0};
    vecs[10] = '{32'h7FFF_FFFF, 32'h8000_0000, VOTE_ALL, 4'd11, 32'd0, 1'b0};
    vecs[11] = '{32'h8000_0000, 32'h8000_0000, VOTE_ANY, 4'd12, 32'd1, 1'b0};
    vecs[12] = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, VOTE_BAL, 4'd13, 32'hAAAA_AAAA, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pred   = '0;
    in_mask   = '0;
    in_op     = VOTE_ALL;
    in_wid    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_wid", {28'd0, out_wid}, 32'd0);
    check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].pred, vecs[i].mask, vecs[i].op, vecs[i].wid, vecs[i].res, vecs[i].ill);
    end
    drain("drain_table");

    for (int i = 0; i < 6; i++) begin
      p  = $urandom;
      m  = (i == 0) ? 32'd0 : $urandom;
      op = vote_op_t'($urandom_range(0, 4));
      model(p, m, op, r, il);
      send(p, m, op, 4'(i), r, il);
    end
    drain("drain_random");

    // Consumer stall: result must hold and no new request may be taken.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'hFFFF_0000, VOTE_BAL, 4'd9, 32'h1234_0000, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result", out_result, 32'h1234_0000);
      check("stall_wid", {28'd0, out_wid}, 32'd9);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_sb_empty", sb.size(), 0);

    // Reset on the second ACCUM cycle discards the request.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, VOTE_ANY, 4'd7, 32'd1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", out_result, 32'd0);
    check("mid_rst_wid", {28'd0, out_wid}, 32'd0);
    check("mid_rst_illegal", {31'd0, out_illegal}, 32'd0);
    rises = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) rises++;
    end
    check("mid_rst_no_valid", rises, 0);

    send(32'h0F0F_0F0F, 32'hFFFF_FFFF, VOTE_BAL, 4'd2, 32'h0F0F_0F0F, 1'b0);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
